bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/microondas_pkg.sv | 26 ++
 rtl/bcd_digit_dec.sv | 41 ++++
 rtl/bcd_countdown_timer.sv | 161 ++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Optional feature macro: TIMER_PAUSE_EN adds the PAUSED state.
package microondas_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_ZERO = 4'd0;
   localparam bcd_t BCD_FIVE = 4'd5;
   localparam bcd_t BCD_NINE = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_DONE   = 2'd2
`ifdef TIMER_PAUSE_EN
      ,
      ST_PAUSED = 2'd3
`endif
   } state_e;

   // True for keypad codes that are legal decimal digits.
   function automatic logic bcd_valid(input logic [3:0] v);
      return (v <= BCD_NINE);
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD decade down-counter: parallel load beats decrement, wraps to WRAP
// when decremented from zero and raises borrow_o in that case.
module bcd_digit_dec
   import microondas_pkg::*;
#(
   parameter bcd_t WRAP = BCD_NINE
) (
   input  logic clk,
   input  logic clear,
   input  logic load_i,
   input  bcd_t load_val_i,
   input  logic borrow_i,
   output bcd_t q_o,
   output logic borrow_o
);

   bcd_t q_q;
   bcd_t q_d;

   // Next digit value: load, else decrement with wrap, else hold.
   always_comb begin
      // NOTE: q_d gets its hold value first so every path assigns it and no latch is inferred.
      q_d = q_q;
      if (load_i) begin
         q_d = load_val_i;
      end else if (borrow_i) begin
         q_d = (q_q == BCD_ZERO) ? WRAP : q_q - 4'd1;
      end
   end

   // Digit register with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
      if (clear) q_q <= BCD_ZERO;
      else       q_q <= q_d;
   end

   assign q_o      = q_q;
   assign borrow_o = borrow_i & (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Microwave-style mm:ss BCD countdown timer: keypad digits shift in while
// idle, a 1 Hz tick counts down while running, DONE at 0:00.
// Optional feature macro: TIMER_PAUSE_EN (stop in COUNT pauses instead of clearing).
module bcd_countdown_timer
   import microondas_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       startn,
   input  logic       stopn,
   output logic       enablen,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       zero,
   output logic       done
);

   logic [SYNC_STAGES-1:0] loadn_sync_q;
   logic [SYNC_STAGES-1:0] tick_sync_q;
   logic                   loadn_hist_q;
   logic                   tick_hist_q;
   logic                   load_edge;
   logic                   tick_edge;

   state_e state_q, state_d;
   logic   load_dig;
   bcd_t   min_val, tens_val, ones_val;
   logic   dec_en;
   logic   at_one;
   logic   ones_borrow, tens_borrow, min_borrow;
   bcd_t   min_q, tens_q, ones_q;

   // Synchronizer chains and edge history for the asynchronous strobes.
   always_ff @(posedge clk) begin
      // NOTE: the chains reset to the inputs' idle levels so clear never fabricates an edge.
      if (clear) begin
         loadn_sync_q <= '1;
         tick_sync_q  <= '0;
         loadn_hist_q <= 1'b1;
         tick_hist_q  <= 1'b0;
      end else begin
         loadn_sync_q[0] <= loadn;
         tick_sync_q[0]  <= pgt_1Hz;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            loadn_sync_q[i] <= loadn_sync_q[i-1];
            tick_sync_q[i]  <= tick_sync_q[i-1];
         end
         loadn_hist_q <= loadn_sync_q[SYNC_STAGES-1];
         tick_hist_q  <= tick_sync_q[SYNC_STAGES-1];
      end
   end

   assign load_edge = loadn_hist_q & ~loadn_sync_q[SYNC_STAGES-1];
   assign tick_edge = ~tick_hist_q & tick_sync_q[SYNC_STAGES-1];

   // The next decrement lands on 0:00 exactly when the display reads 0:01.
   assign at_one = (min_q == BCD_ZERO) && (tens_q == BCD_ZERO) && (ones_q == 4'd1);

`ifdef TIMER_PAUSE_EN
   logic stop_armed_q;

   // A second stop in PAUSED only counts after stopn has been released.
   always_ff @(posedge clk) begin
      if (clear || state_q != ST_PAUSED) stop_armed_q <= 1'b0;
      else if (stopn)                    stop_armed_q <= 1'b1;
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (clear) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and digit-control decode.
   always_comb begin
      state_d  = state_q;
      load_dig = 1'b0;
      min_val  = BCD_ZERO;
      tens_val = BCD_ZERO;
      ones_val = BCD_ZERO;
      dec_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!startn && stopn && !zero) begin
               state_d = ST_COUNT;
            end else if (load_edge && bcd_valid(D)) begin
               load_dig = 1'b1;
               min_val  = tens_q;
               tens_val = ones_q;
               ones_val = D;
            end
         end
         ST_COUNT: begin
            if (!stopn) begin
`ifdef TIMER_PAUSE_EN
               state_d  = ST_PAUSED;
`else
               load_dig = 1'b1;
               state_d  = ST_IDLE;
`endif
            end else if (tick_edge) begin
               dec_en = 1'b1;
               if (at_one) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!stopn) begin
               load_dig = 1'b1;
               state_d  = ST_IDLE;
            end else if (load_edge && bcd_valid(D)) begin
               load_dig = 1'b1;
               ones_val = D;
               state_d  = ST_IDLE;
            end
         end
`ifdef TIMER_PAUSE_EN
         ST_PAUSED: begin
            if (!stopn) begin
               if (stop_armed_q) begin
                  load_dig = 1'b1;
                  state_d  = ST_IDLE;
               end
            end else if (!startn) begin
               state_d = ST_COUNT;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   bcd_digit_dec #(.WRAP(BCD_NINE)) u_sec_ones (
      .clk(clk), .clear(clear), .load_i(load_dig), .load_val_i(ones_val),
      .borrow_i(dec_en), .q_o(ones_q), .borrow_o(ones_borrow)
   );

   bcd_digit_dec #(.WRAP(BCD_FIVE)) u_sec_tens (
      .clk(clk), .clear(clear), .load_i(load_dig), .load_val_i(tens_val),
      .borrow_i(ones_borrow), .q_o(tens_q), .borrow_o(tens_borrow)
   );

   bcd_digit_dec #(.WRAP(BCD_NINE)) u_min_ones (
      .clk(clk), .clear(clear), .load_i(load_dig), .load_val_i(min_val),
      .borrow_i(tens_borrow), .q_o(min_q), .borrow_o(min_borrow)
   );

   assign min_ones = min_q;
   assign sec_tens = tens_q;
   assign sec_ones = ones_q;
   assign zero     = (min_q == BCD_ZERO) && (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);
   assign done     = (state_q == ST_DONE);
   assign enablen  = (state_q == ST_COUNT);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed, table-driven bench for bcd_countdown_timer (SYNC_STAGES = 2).
// Expectations follow TIMER_PAUSE_EN when it is defined for the build.
module tb_bcd_countdown_timer;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       clear;
   logic [3:0] D;
   logic       loadn, pgt_1Hz, startn, stopn;
   logic       enablen, zero, done;
   logic [3:0] min_ones, sec_tens, sec_ones;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  d;
      logic [11:0] exp_digits;
      logic        exp_zero;
   } vec_t;

   vec_t vecs [7];

   bcd_countdown_timer #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .clear(clear), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
      .startn(startn), .stopn(stopn), .enablen(enablen), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones), .zero(zero), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic check_digits(input string name, input logic [11:0] exp);
      check(name, {4'h0, min_ones, sec_tens, sec_ones}, {4'h0, exp});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
   endtask

   task automatic key(input logic [3:0] d);
      D = d;
      loadn = 1'b0;
      cycles(4);
      loadn = 1'b1;
      cycles(4);
   endtask

   task automatic tick();
      pgt_1Hz = 1'b1;
      cycles(4);
      pgt_1Hz = 1'b0;
      cycles(4);
   endtask

   task automatic start();
      startn = 1'b0;
      cycles(2);
      startn = 1'b1;
      cycles(1);
   endtask

   task automatic stop();
      stopn = 1'b0;
      cycles(2);
      stopn = 1'b1;
      cycles(2);
   endtask

   initial begin
      vecs[0] = '{d: 4'd1,  exp_digits: 12'h001, exp_zero: 1'b0};
      vecs[1] = '{d: 4'd3,  exp_digits: 12'h013, exp_zero: 1'b0};
      vecs[2] = '{d: 4'd0,  exp_digits: 12'h130, exp_zero: 1'b0};
      vecs[3] = '{d: 4'd12, exp_digits: 12'h130, exp_zero: 1'b0};
      vecs[4] = '{d: 4'd15, exp_digits: 12'h130, exp_zero: 1'b0};
      vecs[5] = '{d: 4'd7,  exp_digits: 12'h307, exp_zero: 1'b0};
      vecs[6] = '{d: 4'd9,  exp_digits: 12'h079, exp_zero: 1'b0};

      clear = 1'b1; D = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0; startn = 1'b1; stopn = 1'b1;
      cycles(2);
      check_digits("reset_digits", 12'h000);
      check("reset_zero", 16'(zero), 16'd1);
      check("reset_enablen", 16'(enablen), 16'd0);
      check("reset_done", 16'(done), 16'd0);
      clear = 1'b0;
      cycles(1);

      // Keypad entry in IDLE, including out-of-range codes.
      for (int i = 0; i < 7; i++) begin
         key(vecs[i].d);
         check_digits($sformatf("key_vec%0d_digits", i), vecs[i].exp_digits);
         check($sformatf("key_vec%0d_zero", i), 16'(zero), 16'(vecs[i].exp_zero));
         check($sformatf("key_vec%0d_enablen", i), 16'(enablen), 16'd0);
      end

      // startn with zero=1 is ignored.
      do_clear();
      start();
      check("start_at_zero_enablen", 16'(enablen), 16'd0);

      // Exact loadn latency: SYNC+1 edges after the first sampling edge.
      D = 4'd3;
      loadn = 1'b0;
      cycles(SYNC);
      check_digits("latency_before", 12'h000);
      cycles(1);
      check_digits("latency_at", 12'h003);
      loadn = 1'b1;
      cycles(4);

      // loadn held low for 50 cycles shifts once.
      D = 4'd2;
      loadn = 1'b0;
      cycles(50);
      loadn = 1'b1;
      cycles(4);
      check_digits("hold_low_one_shift", 12'h032);

      // Tick ignored in IDLE.
      tick();
      check_digits("tick_in_idle", 12'h032);

      // 1:00 countdown to DONE.
      do_clear();
      key(4'd1); key(4'd0); key(4'd0);
      check_digits("load_100", 12'h100);
      start();
      check("count_enablen", 16'(enablen), 16'd1);
      tick();
      check_digits("first_tick_059", 12'h059);
      key(4'd5);
      check_digits("loadn_in_count", 12'h059);
      repeat (58) tick();
      check_digits("count_001", 12'h001);
      check("count_001_done", 16'(done), 16'd0);
      tick();
      check_digits("count_000", 12'h000);
      check("done_flag", 16'(done), 16'd1);
      check("done_enablen", 16'(enablen), 16'd0);
      check("done_zero", 16'(zero), 16'd1);
      tick();
      check_digits("tick_in_done", 12'h000);
      key(4'd4);
      check_digits("done_load", 12'h004);
      check("done_load_done", 16'(done), 16'd0);
      check("done_load_enablen", 16'(enablen), 16'd0);
      start();
      repeat (4) tick();
      check("second_done", 16'(done), 16'd1);
      stop();
      check("done_stop_done", 16'(done), 16'd0);
      check("done_stop_enablen", 16'(enablen), 16'd0);
      check_digits("done_stop_digits", 12'h000);

      // Entered tens of 7 count down normally.
      do_clear();
      key(4'd7); key(4'd5);
      start();
      tick();
      check_digits("tens7_074", 12'h074);
      repeat (15) tick();
      check_digits("tens7_059", 12'h059);

      // Stop at 0:42.
      do_clear();
      key(4'd4); key(4'd2);
      start();
      stop();
`ifdef TIMER_PAUSE_EN
      check_digits("pause_digits", 12'h042);
      check("pause_enablen", 16'(enablen), 16'd0);
      start();
      check("resume_enablen", 16'(enablen), 16'd1);
      tick();
      check_digits("resume_041", 12'h041);
      stop();
      stop();
      check_digits("pause_second_stop", 12'h000);
      check("pause_second_stop_enablen", 16'(enablen), 16'd0);
`else
      check_digits("stop_digits", 12'h000);
      check("stop_enablen", 16'(enablen), 16'd0);
`endif

      // Tick edge coinciding with IDLE->COUNT is dropped.
      do_clear();
      key(4'd1); key(4'd5);
      pgt_1Hz = 1'b1;
      cycles(SYNC);
      startn = 1'b0;
      cycles(1);
      startn = 1'b1;
      check("coincide_enablen", 16'(enablen), 16'd1);
      check_digits("coincide_digits", 12'h015);
      cycles(3);
      pgt_1Hz = 1'b0;
      cycles(4);
      check_digits("coincide_after", 12'h015);
      tick();
      check_digits("coincide_next_tick", 12'h014);
      startn = 1'b0; stopn = 1'b0;
      cycles(2);
      startn = 1'b1; stopn = 1'b1;
      cycles(2);
      check("both_low_count_enablen", 16'(enablen), 16'd0);
`ifdef TIMER_PAUSE_EN
      check_digits("both_low_count_digits", 12'h014);
`else
      check_digits("both_low_count_digits", 12'h000);
`endif

      // Clear in the middle of a count and of a tick edge.
      do_clear();
      key(4'd2); key(4'd1); key(4'd7);
      start();
      tick();
      check_digits("mid_216", 12'h216);
      pgt_1Hz = 1'b1;
      cycles(1);
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      check_digits("mid_clear_digits", 12'h000);
      check("mid_clear_zero", 16'(zero), 16'd1);
      check("mid_clear_enablen", 16'(enablen), 16'd0);
      check("mid_clear_done", 16'(done), 16'd0);
      cycles(4);
      pgt_1Hz = 1'b0;
      cycles(4);
      check_digits("mid_clear_after", 12'h000);

      // startn and stopn together in IDLE: stop wins, nothing starts.
      key(4'd2); key(4'd1); key(4'd7);
      startn = 1'b0; stopn = 1'b0;
      cycles(2);
      startn = 1'b1; stopn = 1'b1;
      cycles(2);
      check("both_low_idle_enablen", 16'(enablen), 16'd0);
      check_digits("both_low_idle_digits", 12'h217);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
